uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver. It consumes the 16x-oversampling tick from the baud rate
//  generator and deserialises 8N1-style frames on the rx line, LSB first. Each completed
//  frame produces a parallel word and a one-cycle done strobe. It sits between the
//  board rx pin and the downstream FIFO/interface logic.
// PARAMETERS
//  DBIT     8   number of data bits per frame
//  SB_TICK  16  s_tick count for stop bit (16 = 1 stop, 24 = 1.5, 32 = 2)
// PORTS
//  clk           in   1     system clock, single clock domain
//  reset         in   1     synchronous, active-high reset
//  s_tick        in   1     one-clk pulse at 16x baud, from baud rate generator
//  rx            in   1     asynchronous serial input, idle high
//  rx_done_tick  out  1     one-clk strobe: frame complete, dout/frame_err valid
//  dout          out  DBIT  received word, held until next completed frame
//  frame_err     out  1     stop bit sampled low on last frame, held until next frame
// BEHAVIOUR
//  - rx passes through a 2-FF synchronizer (both FFs reset to 1); the FSM sees rx_s only.
//  - Reset: state=IDLE, s=0, n=0, shift=0, dout=0, frame_err=0, rx_done_tick=0.
//    Reset mid-frame aborts the frame with no done strobe.
//  - Counters: s[3:0] counts s_tick within a bit (width covers SB_TICK-1); n counts data bits.
//    They advance only on clocks where s_tick=1; all other clocks hold them.
//  - IDLE: rx_s==0 -> START, s<=0. s_tick is ignored in IDLE.
//  - START: on s_tick, if s==7 (mid start bit): rx_s==0 -> DATA, s<=0, n<=0;
//    rx_s==1 -> IDLE (glitch rejected, no strobe). Otherwise s<=s+1.
//  - DATA: on s_tick, if s==15: s<=0, shift<={rx_s, shift[DBIT-1:1]};
//    if n==DBIT-1 -> STOP, else n<=n+1. Otherwise s<=s+1. Samples fall at mid-bit.
//  - STOP: on s_tick, if s==SB_TICK-1: dout<=shift, frame_err<=~rx_s, rx_done_tick<=1.
//    Next state is IDLE if rx_s==1, BREAK if rx_s==0. Otherwise s<=s+1.
//  - BREAK: wait for rx_s==1 -> IDLE. A line held low (break) yields exactly one framed
//    word (frame_err=1). No new start is accepted until the line returns high.
//  - rx_done_tick is registered. It is high exactly one clk, in the cycle after the edge
//    that samples the stop bit. dout and frame_err change only on that same edge.
//  - Latency: rx falling edge to rx_done_tick is about 2 clk (sync) + (7+16*DBIT+SB_TICK)
//    s_ticks + 1 clk.
//  - A start edge in IDLE directly after STOP is accepted, so back-to-back frames need no gap.
// TESTING (bench drives s_tick every 4 clk; 1 bit = 16 ticks = 64 clk)
//  1. Frame 0x55, valid stop -> one rx_done_tick pulse; dout=0x55, frame_err=0.
//  2. Back-to-back frames 0xA3 then 0x0F, no idle gap -> two pulses, dout=0xA3 then 0x0F.
//  3. rx low for 4 ticks, then high (start glitch) -> no pulse, FSM back in IDLE.
//     A following 0x3C is received correctly.
//  4. Data 0x81 with stop bit low, rx held low for 3 frame-times -> one pulse, dout=0x81,
//     frame_err=1, no further pulses. rx high then frame 0x42 -> dout=0x42, frame_err=0.
//  5. reset pulsed after 4 data bits of 0xF0 -> outputs 0, no pulse for that frame.
//     The next frame 0x99 -> dout=0x99.
//  6. s_tick forced 0 while rx toggles -> FSM never leaves START, no pulse.
//     Restoring s_tick with rx high -> back to IDLE.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver for 8N1-style frames, LSB first.
// Produces a parallel word with a one-cycle done strobe and a framing-error
// flag. A line held low after a frame (break) is reported once; no new start
// is accepted until the line returns high.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err
);

  // Tick counter must reach SB_TICK-1 and 15 (full data bit).
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shift;
  logic            rx_meta;
  logic            rx_s;

  // Two-stage synchronizer for the asynchronous rx pin; resets to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with registered outputs; counters advance only on s_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s     <= '0;
              shift <= {rx_s, shift[DBIT-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              dout         <= shift;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              state        <= rx_s ? IDLE : BREAK;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; s_tick every 4 clk, 64 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned pulses;
  logic [7:0]  rec_dout [0:31];
  logic        rec_ferr [0:31];
  logic        tick_en;
  int unsigned tick_cnt;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick generator: one-clk pulse every 4 clk while enabled.
  initial begin
    s_tick   = 1'b0;
    tick_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_cnt = tick_cnt + 1;
      s_tick = tick_en && ((tick_cnt % 4) == 0);
    end
  end

  // Done-strobe monitor, sampled on the falling edge.
  initial begin
    pulses = 0;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        if (pulses < 32) begin
          rec_dout[pulses] = dout;
          rec_ferr[pulses] = frame_err;
        end
        pulses = pulses + 1;
      end
    end
  end

  task automatic wait_clk(input int unsigned k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      rx = d[i];
      wait_clk(64);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sb);
    rx = 1'b0;
    wait_clk(64);
    send_bits(d, 8);
    rx = sb;
    wait_clk(64);
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    rx      = 1'b1;
    tick_en = 1'b1;
    wait_clk(6);
    vectors++;
    if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: dout=%h ferr=%b done=%b want 00/0/0", dout, frame_err, rx_done_tick);
    end
    reset = 1'b0;
    wait_clk(100);
    vectors++;
    if (pulses !== 0 || dout !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_idle: pulses=%0d dout=%h want 0/00", pulses, dout);
    end
  endtask

  task automatic test_single;
    int unsigned p0;
    p0 = pulses;
    send_frame(8'h55, 1'b1);
    wait_clk(20);
    vectors++;
    if (pulses - p0 !== 1) begin
      miscompares++;
      $display("FAIL single_pulses: got %0d want 1", pulses - p0);
    end else begin
      vectors++;
      if (rec_dout[p0] !== 8'h55 || rec_ferr[p0] !== 1'b0) begin
        miscompares++;
        $display("FAIL single_data: dout=%h ferr=%b want 55/0", rec_dout[p0], rec_ferr[p0]);
      end
    end
    vectors++;
    if (dout !== 8'h55) begin
      miscompares++;
      $display("FAIL single_hold: dout=%h want 55", dout);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned p0;
    p0 = pulses;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_clk(20);
    vectors++;
    if (pulses - p0 !== 2) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses - p0);
    end else begin
      vectors++;
      if (rec_dout[p0] !== 8'hA3 || rec_ferr[p0] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_first: dout=%h ferr=%b want A3/0", rec_dout[p0], rec_ferr[p0]);
      end
      vectors++;
      if (rec_dout[p0+1] !== 8'h0F || rec_ferr[p0+1] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_second: dout=%h ferr=%b want 0F/0", rec_dout[p0+1], rec_ferr[p0+1]);
      end
    end
  endtask

  task automatic test_glitch;
    int unsigned p0;
    p0 = pulses;
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(200);
    vectors++;
    if (pulses !== p0) begin
      miscompares++;
      $display("FAIL glitch_pulses: got %0d want 0", pulses - p0);
    end
    send_frame(8'h3C, 1'b1);
    wait_clk(20);
    vectors++;
    if (pulses - p0 !== 1 || rec_dout[p0] !== 8'h3C || rec_ferr[p0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_after: pulses=%0d dout=%h want 1/3C", pulses - p0, dout);
    end
  endtask

  task automatic test_break;
    int unsigned p0;
    p0 = pulses;
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    wait_clk(3 * 640);
    vectors++;
    if (pulses - p0 !== 1) begin
      miscompares++;
      $display("FAIL break_pulses: got %0d want 1", pulses - p0);
    end else begin
      vectors++;
      if (rec_dout[p0] !== 8'h81 || rec_ferr[p0] !== 1'b1) begin
        miscompares++;
        $display("FAIL break_data: dout=%h ferr=%b want 81/1", rec_dout[p0], rec_ferr[p0]);
      end
    end
    rx = 1'b1;
    wait_clk(200);
    send_frame(8'h42, 1'b1);
    wait_clk(20);
    vectors++;
    if (pulses - p0 !== 2 || dout !== 8'h42 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL break_recover: pulses=%0d dout=%h ferr=%b want 2/42/0", pulses - p0, dout, frame_err);
    end
  endtask

  task automatic test_reset_midframe;
    int unsigned p0;
    p0 = pulses;
    rx = 1'b0;
    wait_clk(64);
    send_bits(8'hF0, 4);
    rx = 1'b1;
    reset = 1'b1;
    wait_clk(2);
    vectors++;
    if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_out: dout=%h ferr=%b done=%b want 00/0/0", dout, frame_err, rx_done_tick);
    end
    reset = 1'b0;
    wait_clk(62 + 3 * 64 + 64 + 100);
    vectors++;
    if (pulses !== p0) begin
      miscompares++;
      $display("FAIL midreset_pulses: got %0d want 0", pulses - p0);
    end
    send_frame(8'h99, 1'b1);
    wait_clk(20);
    vectors++;
    if (pulses - p0 !== 1 || dout !== 8'h99 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_next: pulses=%0d dout=%h want 1/99", pulses - p0, dout);
    end
  endtask

  task automatic test_no_tick;
    int unsigned p0;
    p0 = pulses;
    tick_en = 1'b0;
    wait_clk(8);
    for (int unsigned i = 0; i < 6; i++) begin
      rx = ~rx;
      wait_clk(40);
    end
    rx = 1'b0;
    wait_clk(300);
    vectors++;
    if (pulses !== p0) begin
      miscompares++;
      $display("FAIL notick_pulses: got %0d want 0", pulses - p0);
    end
    rx = 1'b1;
    wait_clk(4);
    tick_en = 1'b1;
    wait_clk(100);
    vectors++;
    if (pulses !== p0) begin
      miscompares++;
      $display("FAIL notick_restore: got %0d pulses want 0", pulses - p0);
    end
    send_frame(8'hC5, 1'b1);
    wait_clk(20);
    vectors++;
    if (pulses - p0 !== 1 || dout !== 8'hC5 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL notick_after: pulses=%0d dout=%h want 1/C5", pulses - p0, dout);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tick_en     = 1'b0;
    reset       = 1'b1;
    rx          = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_no_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
